// File: rtl/cpu15_pkg.sv
// Shared definitions for the 15-bit CPU: sequencer state encoding and default widths.
// Used by the sequencer, the fetch/decode stages and the testbench.
// No logic; types and constants only.
package cpu15_pkg;

  localparam int PC_WIDTH_DEF  = 8;
  localparam int CNT_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WBACK  = 3'd4,
    ST_HALT   = 3'd5
  } seq_state_e;

endpackage

// File: rtl/cpu15_sequencer.sv
// Phase controller: steps fetch/decode/exec/writeback with one-hot enables, owns P_COUNT and RETIRED.
// Latency: 4 cycles per unstalled instruction; first EN_FT one cycle after START is sampled high.
// Backpressure: STALL holds the current phase and its strobe. Optional macro CPU15_SINGLE_STEP_EN adds STEP.
module cpu15_sequencer
  import cpu15_pkg::*;
#(
  parameter int PC_WIDTH  = PC_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  input  logic                 STALL,
  input  logic                 JMP_EN,
  input  logic [PC_WIDTH-1:0]  JMP_ADDR,
  input  logic                 HLT_REQ,
`ifdef CPU15_SINGLE_STEP_EN
  input  logic                 STEP,
`endif
  output logic                 EN_FT,
  output logic                 EN_DC,
  output logic                 EN_EX,
  output logic                 EN_WB,
  output logic [PC_WIDTH-1:0]  P_COUNT,
  output logic                 HALTED,
  output logic [CNT_WIDTH-1:0] RETIRED
);

  seq_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 go_idle;

`ifdef CPU15_SINGLE_STEP_EN
  logic step_q;
  // A STEP rising edge or START releases IDLE; every completed instruction returns to IDLE.
  assign go_idle = START | (STEP & ~step_q);
`else
  assign go_idle = START;
`endif

  // State, program counter and retire counter registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      retired_q <= '0;
`ifdef CPU15_SINGLE_STEP_EN
      step_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
`ifdef CPU15_SINGLE_STEP_EN
      step_q    <= STEP;
`endif
    end
  end

  // Next-state logic; the PC and retire count only move when an instruction leaves WBACK.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    unique case (state_q)
      ST_IDLE: begin
        if (go_idle) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (!STALL) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (!STALL) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (!STALL) state_d = ST_WBACK;
      end
      ST_WBACK: begin
        if (!STALL) begin
          retired_d = retired_q + CNT_WIDTH'(1);
          if (HLT_REQ) begin
            // Halt beats a simultaneous jump; PC keeps the hlt address.
            state_d = ST_HALT;
          end else begin
            if (JMP_EN) pc_d = JMP_ADDR;
            else        pc_d = pc_q + PC_WIDTH'(1);
`ifdef CPU15_SINGLE_STEP_EN
            state_d = ST_IDLE;
`else
            state_d = ST_FETCH;
`endif
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore outputs decoded straight from the state register.
  always_comb begin
    EN_FT   = (state_q == ST_FETCH);
    EN_DC   = (state_q == ST_DECODE);
    EN_EX   = (state_q == ST_EXEC);
    EN_WB   = (state_q == ST_WBACK);
    HALTED  = (state_q == ST_HALT);
    P_COUNT = pc_q;
    RETIRED = retired_q;
  end

endmodule
